mem_slice: RTL and testbench

MEM_SLICE -- requirements
Module: mem_slice

---
 rtl/mem_slice.sv | 125 ++++++++++++
 tb/tb_mem_slice.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_slice.sv
// MEM pipeline stage: holds the EX/MEM register, sequences one data-memory
// access per instruction (with wait states and a timeout) and stalls upstream.
module mem_slice #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [6:0]  WB_in,
  input  logic [1:0]  M_in,
  input  logic [15:0] addr_in,
  input  logic [15:0] data_in,
  input  logic [15:0] result_in,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [6:0]  WB,
  output logic [15:0] rdata,
  output logic [15:0] result,
  output logic        mem_stall,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [6:0]  WB_q;
  logic [1:0]  M_q;
  logic [15:0] addr_q, data_q, result_q, rdata_q;

  logic        op, is_write, is_read;
  logic        load, timeout, complete;
  logic [15:0] complete_rdata;

  assign op       = |M_q;
  assign is_write = M_q[0];
  assign is_read  = (M_q == 2'b10);

  // Kept outside the FSM process so load/mem_stall never loop through it.
  assign timeout   = (state == BUSY) && (cnt == TIMEOUT_CNT) && !mem_ready;
  assign complete  = ((state == IDLE) && op && mem_ready) ||
                     ((state == BUSY) && (mem_ready || timeout));
  assign mem_stall = op && (state != DONE) && !mem_ready && !timeout;
  assign load      = !stall && !mem_stall;

  assign complete_rdata = (is_read && !timeout) ? mem_rdata : '0;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_req   = 1'b0;
    unique case (state)
      IDLE: begin
        mem_req = op;
        if (complete) begin
          state_nxt = load ? IDLE : DONE;
        end else if (op) begin
          state_nxt = BUSY;
          cnt_nxt   = 8'd1;
        end
      end
      BUSY: begin
        mem_req = 1'b1;
        if (complete) begin
          state_nxt = load ? IDLE : DONE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      DONE: begin
        if (load) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WB_q     <= '0;
      M_q      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      result_q <= '0;
    end else if (load) begin
      WB_q     <= flush ? '0 : WB_in;
      M_q      <= flush ? '0 : M_in;
      addr_q   <= addr_in;
      data_q   <= data_in;
      result_q <= result_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      mem_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (complete) rdata_q <= complete_rdata;
      if (timeout)  mem_err <= 1'b1;
    end
  end

  assign mem_we    = mem_req && is_write;
  assign mem_addr  = mem_req ? addr_q : '0;
  assign mem_wdata = mem_req ? data_q : '0;

  // While stalled the MEM/WB stage must see a bubble, not the held instruction.
  assign WB     = mem_stall ? '0 : WB_q;
  assign rdata  = (state == DONE) ? rdata_q : (complete ? complete_rdata : '0);
  assign result = result_q;

endmodule

// File: tb/tb_mem_slice.sv
// Directed bench for mem_slice: stimulus pushes expected completions into a
// scoreboard that a negedge monitor pops; cycle-level behaviour checked inline.
module tb_mem_slice;

  logic        clk, rst_n, stall, flush;
  logic [6:0]  WB_in;
  logic [1:0]  M_in;
  logic [15:0] addr_in, data_in, result_in, mem_rdata;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_stall, mem_err;
  logic [15:0] mem_addr, mem_wdata, rdata, result;
  logic [6:0]  WB;

  mem_slice #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .WB_in(WB_in), .M_in(M_in), .addr_in(addr_in), .data_in(data_in),
    .result_in(result_in), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .WB(WB), .rdata(rdata), .result(result), .mem_stall(mem_stall), .mem_err(mem_err)
  );

  typedef struct {
    logic [6:0]  wb;
    logic [15:0] rdata;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] result;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [6:0] wb, input logic [1:0] m, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] r);
    WB_in = wb; M_in = m; addr_in = a; data_in = d; result_in = r;
  endtask

  task automatic push(input logic [6:0] wb, input logic [15:0] rd, input logic we,
                      input logic [15:0] a, input logic [15:0] wd, input logic [15:0] r,
                      input logic err);
    exp_t e;
    e.wb = wb; e.rdata = rd; e.we = we; e.addr = a; e.wdata = wd; e.result = r; e.err = err;
    sb_q.push_back(e);
  endtask

  // Monitor: an access completes whenever a request is presented without a stall.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && mem_req && !mem_stall) begin
        if (sb_q.size() == 0) begin
          check("unexpected completion addr", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb WB",        32'(WB),        32'(e.wb));
          check("sb rdata",     32'(rdata),     32'(e.rdata));
          check("sb mem_we",    32'(mem_we),    32'(e.we));
          check("sb mem_addr",  32'(mem_addr),  32'(e.addr));
          check("sb mem_wdata", 32'(mem_wdata), 32'(e.wdata));
          check("sb result",    32'(result),    32'(e.result));
          check("sb mem_err",   32'(mem_err),   32'(e.err));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    set_in(7'h7F, 2'b10, 16'h0001, 16'h0002, 16'h0003);
    mem_ready = 1'b0; mem_rdata = 16'hDEAD;
    #1 rst_n = 1'b0;
    #1;
    check("rst mem_req",   32'(mem_req),   32'd0);
    check("rst mem_we",    32'(mem_we),    32'd0);
    check("rst WB",        32'(WB),        32'd0);
    check("rst rdata",     32'(rdata),     32'd0);
    check("rst result",    32'(result),    32'd0);
    check("rst mem_stall", 32'(mem_stall), 32'd0);
    check("rst mem_err",   32'(mem_err),   32'd0);
    @(negedge clk) rst_n = 1'b1;
    set_in(7'h00, 2'b00, 16'h0000, 16'h0000, 16'h0000);
    step();

    // Zero-wait read.
    set_in(7'h55, 2'b10, 16'h0040, 16'h0000, 16'h1111);
    mem_ready = 1'b1; mem_rdata = 16'h1234;
    step();
    set_in(7'h00, 2'b00, 16'h0000, 16'h0000, 16'h0000);
    push(7'h55, 16'h1234, 1'b0, 16'h0040, 16'h0000, 16'h1111, 1'b0);
    @(negedge clk);
    check("zw read mem_stall", 32'(mem_stall), 32'd0);
    step();

    // Back-to-back zero-wait accesses: M=11 behaves as a write, then a read.
    set_in(7'h11, 2'b11, 16'h0070, 16'h1357, 16'h0AAA);
    mem_rdata = 16'h9999;
    step();
    push(7'h11, 16'h0000, 1'b1, 16'h0070, 16'h1357, 16'h0AAA, 1'b0);
    set_in(7'h12, 2'b10, 16'h0072, 16'h0000, 16'h0BBB);
    step();
    push(7'h12, 16'h9999, 1'b0, 16'h0072, 16'h0000, 16'h0BBB, 1'b0);
    set_in(7'h00, 2'b00, 16'h0000, 16'h0000, 16'h0000);
    step();

    // 3-wait write; flush pulsed mid-stall must be ignored.
    mem_ready = 1'b0;
    set_in(7'h2A, 2'b01, 16'h0010, 16'hBEEF, 16'h2222);
    step();
    set_in(7'h33, 2'b10, 16'h0020, 16'h0000, 16'h3333);
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      @(negedge clk);
      check("wr wait mem_stall", 32'(mem_stall), 32'd1);
      check("wr wait WB",        32'(WB),        32'd0);
      check("wr wait mem_we",    32'(mem_we),    32'd1);
      check("wr wait mem_wdata", 32'(mem_wdata), 32'hBEEF);
      step();
    end
    flush = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h5555;
    push(7'h2A, 16'h0000, 1'b1, 16'h0010, 16'hBEEF, 16'h2222, 1'b0);
    @(negedge clk);
    check("wr done mem_stall", 32'(mem_stall), 32'd0);
    step();

    // The next read loaded on the 4th edge; it completes while stall holds the stage.
    stall = 1'b1; mem_rdata = 16'h00AA;
    set_in(7'h00, 2'b00, 16'h0000, 16'h0000, 16'h0000);
    push(7'h33, 16'h00AA, 1'b0, 16'h0020, 16'h0000, 16'h3333, 1'b0);
    @(negedge clk);
    check("next load addr", 32'(mem_addr), 32'h0020);
    step();
    flush = 1'b1; mem_ready = 1'b0; mem_rdata = 16'hFFFF;
    @(negedge clk);
    check("done1 mem_req", 32'(mem_req), 32'd0);
    check("done1 rdata",   32'(rdata),   32'h00AA);
    check("done1 WB",      32'(WB),      32'h33);
    step();
    stall = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("done2 mem_req", 32'(mem_req), 32'd0);
    check("done2 rdata",   32'(rdata),   32'h00AA);
    check("done2 WB",      32'(WB),      32'h33);
    step();

    // Read that never gets mem_ready: 4 stall cycles, then abandoned.
    set_in(7'h44, 2'b10, 16'h0030, 16'h0000, 16'h4444);
    mem_rdata = 16'h7777;
    step();
    set_in(7'h00, 2'b00, 16'h0000, 16'h0000, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("to wait mem_stall", 32'(mem_stall), 32'd1);
      check("to wait mem_err",   32'(mem_err),   32'd0);
      step();
    end
    push(7'h44, 16'h0000, 1'b0, 16'h0030, 16'h0000, 16'h4444, 1'b0);
    @(negedge clk);
    check("to release mem_stall", 32'(mem_stall), 32'd0);
    step();
    @(negedge clk);
    check("to mem_err set", 32'(mem_err), 32'd1);
    check("to after req",   32'(mem_req), 32'd0);
    repeat (3) step();
    @(negedge clk);
    check("to mem_err sticky", 32'(mem_err), 32'd1);

    // Flush turns a read into a bubble.
    set_in(7'h66, 2'b10, 16'h0050, 16'h0000, 16'h6666);
    flush = 1'b1; mem_ready = 1'b1;
    step();
    flush = 1'b0;
    set_in(7'h00, 2'b00, 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk);
    check("flush mem_req", 32'(mem_req), 32'd0);
    check("flush WB",      32'(WB),      32'd0);
    check("flush result",  32'(result),  32'h6666);
    step();

    // Reset asserted mid-BUSY clears everything without a clock edge.
    set_in(7'h77, 2'b10, 16'h0060, 16'h0000, 16'h7777);
    mem_ready = 1'b0;
    step();
    set_in(7'h00, 2'b00, 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk);
    check("busy mem_stall", 32'(mem_stall), 32'd1);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("async rst mem_req",   32'(mem_req),   32'd0);
    check("async rst mem_we",    32'(mem_we),    32'd0);
    check("async rst mem_addr",  32'(mem_addr),  32'd0);
    check("async rst WB",        32'(WB),        32'd0);
    check("async rst rdata",     32'(rdata),     32'd0);
    check("async rst result",    32'(result),    32'd0);
    check("async rst mem_stall", 32'(mem_stall), 32'd0);
    check("async rst mem_err",   32'(mem_err),   32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      check("post rst mem_req",   32'(mem_req),   32'd0);
      check("post rst mem_stall", 32'(mem_stall), 32'd0);
    end

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
